// File: rtl/read_header_func.sv
// Receive-side Ethernet frame capture: latches one header into three single-entry
// memories, streams payload bytes into a byte memory, then holds valid until reset.
module read_header_func #(
  parameter int PAYLOAD_AW = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arg_3_m_eth_hdr_valid,
  output logic                  arg_3_m_eth_hdr_ready,
  input  logic [47:0]           arg_3_m_eth_dest_mac,
  input  logic [47:0]           arg_3_m_eth_src_mac,
  input  logic [15:0]           arg_3_m_eth_type,
  input  logic [7:0]            arg_3_m_eth_payload_axis_tdata,
  input  logic                  arg_3_m_eth_payload_axis_tvalid,
  output logic                  arg_3_m_eth_payload_axis_tready,
  input  logic                  arg_3_m_eth_payload_axis_tlast,
  input  logic                  arg_3_m_eth_payload_axis_tuser,
  output logic [47:0]           arg_0_raddr,
  output logic [47:0]           arg_0_waddr,
  output logic [47:0]           arg_0_wdata,
  output logic                  arg_0_wen,
  input  logic [47:0]           arg_0_rdata,
  output logic [47:0]           arg_1_raddr,
  output logic [47:0]           arg_1_waddr,
  output logic [47:0]           arg_1_wdata,
  output logic                  arg_1_wen,
  input  logic [47:0]           arg_1_rdata,
  output logic [15:0]           arg_2_raddr,
  output logic [15:0]           arg_2_waddr,
  output logic [15:0]           arg_2_wdata,
  output logic                  arg_2_wen,
  input  logic [15:0]           arg_2_rdata,
  output logic [PAYLOAD_AW-1:0] arg_4_waddr,
  output logic [7:0]            arg_4_wdata,
  output logic                  arg_4_wen,
  output logic [15:0]           payload_len,
  output logic                  payload_err,
  output logic                  valid
);

  typedef enum logic [1:0] {
    WAIT_HDR  = 2'd0,
    WRITE_HDR = 2'd1,
    PAYLOAD   = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [16:0] CAP = 17'd1 << PAYLOAD_AW;

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? 16'hFFFF : x + 16'd1;
  endfunction

  state_t      state_q;
  logic [47:0] dest_q, src_q;
  logic [15:0] type_q;
  logic [15:0] count_q, count_d;
  logic        ovf_q;
  logic [15:0] len_q;
  logic        err_q;
  logic        beat, in_cap, wr;

  // Read ports of the header memories are never used by this block.
  logic unused_rdata;
  assign unused_rdata = ^{arg_0_rdata, arg_1_rdata, arg_2_rdata};

  assign beat    = (state_q == PAYLOAD) && arg_3_m_eth_payload_axis_tvalid;
  assign in_cap  = ({1'b0, count_q} < CAP);
  assign wr      = beat && in_cap;
  assign count_d = sat_inc(count_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_HDR;
      count_q <= '0;
      ovf_q   <= 1'b0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        WAIT_HDR: begin
          if (arg_3_m_eth_hdr_valid) begin
            state_q <= WRITE_HDR;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        WRITE_HDR: state_q <= PAYLOAD;
        PAYLOAD: begin
          if (beat) begin
            count_q <= count_d;
            if (!in_cap) ovf_q <= 1'b1;
            if (arg_3_m_eth_payload_axis_tlast) begin
              // The tlast byte itself may be the one that overflows.
              len_q   <= count_d;
              err_q   <= arg_3_m_eth_payload_axis_tuser | ovf_q | ~in_cap;
              state_q <= DONE;
            end
          end
        end
        default: state_q <= DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == WAIT_HDR && arg_3_m_eth_hdr_valid) begin
      dest_q <= arg_3_m_eth_dest_mac;
      src_q  <= arg_3_m_eth_src_mac;
      type_q <= arg_3_m_eth_type;
    end
  end

  assign arg_3_m_eth_hdr_ready           = (state_q == WAIT_HDR);
  assign arg_3_m_eth_payload_axis_tready = (state_q == PAYLOAD);

  assign arg_0_wen   = (state_q == WRITE_HDR);
  assign arg_1_wen   = (state_q == WRITE_HDR);
  assign arg_2_wen   = (state_q == WRITE_HDR);
  assign arg_0_raddr = '0;
  assign arg_1_raddr = '0;
  assign arg_2_raddr = '0;
  assign arg_0_waddr = '0;
  assign arg_1_waddr = '0;
  assign arg_2_waddr = '0;
  assign arg_0_wdata = arg_0_wen ? dest_q : '0;
  assign arg_1_wdata = arg_1_wen ? src_q  : '0;
  assign arg_2_wdata = arg_2_wen ? type_q : '0;

  assign arg_4_wen   = wr;
  assign arg_4_waddr = wr ? count_q[PAYLOAD_AW-1:0] : '0;
  assign arg_4_wdata = wr ? arg_3_m_eth_payload_axis_tdata : '0;

  assign payload_len = len_q;
  assign payload_err = err_q;
  assign valid       = (state_q == DONE);

endmodule

// File: tb/tb_read_header_func.sv
// Directed bench for read_header_func: header capture, payload stream, overflow,
// error flag and mid-frame reset, with a write-capturing memory model.
module tb_read_header_func;

  logic        clk = 1'b0;
  logic        rst;
  logic        hdr_valid, hdr_ready;
  logic [47:0] dest, src;
  logic [15:0] etype;
  logic [7:0]  tdata;
  logic        tvalid, tready, tlast, tuser;
  logic [47:0] a0_raddr, a0_waddr, a0_wdata, a1_raddr, a1_waddr, a1_wdata;
  logic [15:0] a2_raddr, a2_waddr, a2_wdata;
  logic        a0_wen, a1_wen, a2_wen;
  logic [5:0]  a4_waddr;
  logic [7:0]  a4_wdata;
  logic        a4_wen;
  logic [15:0] plen;
  logic        perr, vld;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem4 [64];
  int          wr4_cnt, h0_cnt, h1_cnt, h2_cnt;
  logic [47:0] h0_val, h1_val;
  logic [15:0] h2_val;

  always #5 clk = ~clk;

  read_header_func #(.PAYLOAD_AW(6)) dut (
    .clk(clk), .rst(rst),
    .arg_3_m_eth_hdr_valid(hdr_valid), .arg_3_m_eth_hdr_ready(hdr_ready),
    .arg_3_m_eth_dest_mac(dest), .arg_3_m_eth_src_mac(src), .arg_3_m_eth_type(etype),
    .arg_3_m_eth_payload_axis_tdata(tdata), .arg_3_m_eth_payload_axis_tvalid(tvalid),
    .arg_3_m_eth_payload_axis_tready(tready), .arg_3_m_eth_payload_axis_tlast(tlast),
    .arg_3_m_eth_payload_axis_tuser(tuser),
    .arg_0_raddr(a0_raddr), .arg_0_waddr(a0_waddr), .arg_0_wdata(a0_wdata),
    .arg_0_wen(a0_wen), .arg_0_rdata(48'h0),
    .arg_1_raddr(a1_raddr), .arg_1_waddr(a1_waddr), .arg_1_wdata(a1_wdata),
    .arg_1_wen(a1_wen), .arg_1_rdata(48'h0),
    .arg_2_raddr(a2_raddr), .arg_2_waddr(a2_waddr), .arg_2_wdata(a2_wdata),
    .arg_2_wen(a2_wen), .arg_2_rdata(16'h0),
    .arg_4_waddr(a4_waddr), .arg_4_wdata(a4_wdata), .arg_4_wen(a4_wen),
    .payload_len(plen), .payload_err(perr), .valid(vld)
  );

  // Memory model: records every write strobe the DUT issues; cleared by reset.
  always @(posedge clk) begin
    if (rst) begin
      wr4_cnt <= 0; h0_cnt <= 0; h1_cnt <= 0; h2_cnt <= 0;
    end else begin
      if (a4_wen) begin
        mem4[a4_waddr] <= a4_wdata;
        wr4_cnt <= wr4_cnt + 1;
      end
      if (a0_wen && a0_waddr == 48'h0) begin h0_cnt <= h0_cnt + 1; h0_val <= a0_wdata; end
      if (a1_wen && a1_waddr == 48'h0) begin h1_cnt <= h1_cnt + 1; h1_val <= a1_wdata; end
      if (a2_wen && a2_waddr == 16'h0) begin h2_cnt <= h2_cnt + 1; h2_val <= a2_wdata; end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    int n;
    @(negedge clk);
    hdr_valid = 1'b1; dest = d; src = s; etype = t;
    chk("hdr_wen_before_handshake", {61'h0, a0_wen, a1_wen, a2_wen}, 64'h0);
    n = 0;
    while (!hdr_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("hdr_ready_timeout", 64'(hdr_ready), 64'h1);
    @(posedge clk); #1 hdr_valid = 1'b0;
    @(negedge clk);
    chk("hdr_wen_after_handshake", {61'h0, a0_wen, a1_wen, a2_wen}, 64'h7);
    chk("hdr_dest_wdata", 64'(a0_wdata), 64'(d));
    chk("hdr_type_wdata", 64'(a2_wdata), 64'(t));
  endtask

  task automatic beat(input logic [7:0] d, input logic last, input logic user);
    int n;
    @(negedge clk);
    tvalid = 1'b1; tdata = d; tlast = last; tuser = user;
    n = 0;
    while (!tready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("tready_timeout", 64'(tready), 64'h1);
    @(posedge clk); #1 tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!vld && n < 50) begin @(negedge clk); n++; end
    chk(tag, 64'(vld), 64'h1);
  endtask

  initial begin
    rst = 1'b1; hdr_valid = 1'b0; dest = '0; src = '0; etype = '0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_hdr_ready", 64'(hdr_ready), 64'h1);
    chk("rst_tready", 64'(tready), 64'h0);
    chk("rst_valid", 64'(vld), 64'h0);
    chk("rst_len", 64'(plen), 64'h0);
    chk("rst_err", 64'(perr), 64'h0);
    chk("rst_wens", {60'h0, a0_wen, a1_wen, a2_wen, a4_wen}, 64'h0);
    chk("rst_addrs", 64'(a4_waddr) | 64'(a0_waddr) | 64'(a4_wdata) | 64'(a0_wdata), 64'h0);

    // Payload beats before the header are refused
    tvalid = 1'b1; tdata = 8'hEE;
    @(negedge clk);
    chk("pre_hdr_tready", 64'(tready), 64'h0);
    tvalid = 1'b0;

    // Idle header interface for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_hdr_ready", 64'(hdr_ready), 64'h1);
    end
    chk("idle_no_hdr_writes", 64'(h0_cnt + h1_cnt + h2_cnt), 64'h0);

    // Frame A: 4 bytes 01..04
    send_hdr(48'h112233445566, 48'hAABBCCDDEEFF, 16'h0800);
    for (int i = 1; i <= 4; i++) beat(8'(i), i == 4, 1'b0);
    wait_valid("A_valid");
    chk("A_h0", 64'(h0_val), 64'h112233445566);
    chk("A_h1", 64'(h1_val), 64'hAABBCCDDEEFF);
    chk("A_h2", 64'(h2_val), 64'h0800);
    chk("A_hdr_counts", {h0_cnt[15:0], h1_cnt[15:0], h2_cnt[15:0]}, {16'd1, 16'd1, 16'd1});
    chk("A_mem", {mem4[0], mem4[1], mem4[2], mem4[3]}, 64'h01020304);
    chk("A_wr_cnt", 64'(wr4_cnt), 64'd4);
    chk("A_len", 64'(plen), 64'd4);
    chk("A_err", 64'(perr), 64'h0);

    // DONE back-pressures any further traffic
    hdr_valid = 1'b1; tvalid = 1'b1; tdata = 8'h55;
    repeat (4) @(negedge clk);
    chk("done_ready", {62'h0, hdr_ready, tready}, 64'h0);
    chk("done_no_writes", 64'(wr4_cnt + h0_cnt), 64'd5);
    chk("done_valid_hold", 64'(vld), 64'h1);
    hdr_valid = 1'b0; tvalid = 1'b0;

    // Frame B: gapped beats 1,0,0,1,0,1
    do_reset();
    chk("B_valid_cleared", 64'(vld), 64'h0);
    send_hdr(48'h0A0B0C0D0E0F, 48'h010203040506, 16'h86DD);
    beat(8'hA1, 1'b0, 1'b0);
    idle(2);
    beat(8'hA2, 1'b0, 1'b0);
    idle(1);
    beat(8'hA3, 1'b1, 1'b0);
    wait_valid("B_valid");
    chk("B_mem", {mem4[0], mem4[1], mem4[2]}, 64'hA1A2A3);
    chk("B_wr_cnt", 64'(wr4_cnt), 64'd3);
    chk("B_len", 64'(plen), 64'd3);
    chk("B_err", 64'(perr), 64'h0);

    // Frame C: 66 bytes overflows a 64-byte memory
    do_reset();
    send_hdr(48'h1, 48'h2, 16'h0003);
    for (int i = 1; i <= 66; i++) beat(8'(i), i == 66, 1'b0);
    wait_valid("C_valid");
    chk("C_wr_cnt", 64'(wr4_cnt), 64'd64);
    chk("C_mem_first", 64'(mem4[0]), 64'h01);
    chk("C_mem_second", 64'(mem4[1]), 64'h02);
    chk("C_mem_last", 64'(mem4[63]), 64'h40);
    chk("C_len", 64'(plen), 64'd66);
    chk("C_err", 64'(perr), 64'h1);

    // Frame D: single byte with tuser on tlast
    do_reset();
    send_hdr(48'h3, 48'h4, 16'h0005);
    beat(8'h7E, 1'b1, 1'b1);
    wait_valid("D_valid");
    chk("D_len", 64'(plen), 64'd1);
    chk("D_err", 64'(perr), 64'h1);
    chk("D_mem", 64'(mem4[0]), 64'h7E);

    // Frame E: reset after 2 of 5 bytes, then a fresh 2-byte frame
    do_reset();
    send_hdr(48'h5, 48'h6, 16'h0007);
    beat(8'hC1, 1'b0, 1'b0);
    beat(8'hC2, 1'b0, 1'b0);
    do_reset();
    chk("E_abort_valid", 64'(vld), 64'h0);
    chk("E_abort_hdr_ready", 64'(hdr_ready), 64'h1);
    chk("E_abort_len", 64'(plen), 64'h0);
    chk("E_abort_no_writes", 64'(wr4_cnt), 64'h0);
    send_hdr(48'h8, 48'h9, 16'h000A);
    beat(8'hB1, 1'b0, 1'b0);
    @(negedge clk);
    chk("E_valid_mid_frame", 64'(vld), 64'h0);
    beat(8'hB2, 1'b1, 1'b0);
    wait_valid("E_valid");
    chk("E_mem", {mem4[0], mem4[1]}, 64'hB1B2);
    chk("E_wr_cnt", 64'(wr4_cnt), 64'd2);
    chk("E_len", 64'(plen), 64'd2);
    chk("E_err", 64'(perr), 64'h0);
    chk("E_h0", 64'(h0_val), 64'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
